bcd_time_counter: RTL and testbench

- Time-of-day counter that produces the packed BCD time word consumed by the display digit multiplexer.
- Format is hh:mm:ss, count[23:0] = {h10,h1,m10,m1,s10,s1}, 4 bits per digit.
- Divides the system clock down to a 1 Hz tick, advances seconds, minutes and hours with carries, and accepts pre-debounced single-cycle set pulses from the button logic.

---
 rtl/bcd_time_counter.sv | 124 ++++++++++++
 tb/tb_bcd_time_counter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss time-of-day counter with 1 Hz prescaler and set pulses; count updates 1 edge after a tick or set.
// Define TWELVE_HOUR_EN for 12-hour display (12,01..11) with an added pm output.
module bcd_time_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        clr_sec,
  output logic [23:0] count,
  output logic        sec_tick,
  output logic        day_wrap
`ifdef TWELVE_HOUR_EN
  ,
  output logic        pm
`endif
);

`ifdef TWELVE_HOUR_EN
  localparam logic [23:0] RST_COUNT = 24'h120000;
`else
  localparam logic [23:0] RST_COUNT = 24'h000000;
`endif
  localparam logic [DIV_W-1:0] PSC_LAST = DIV_W'(TICK_DIV - 1);

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hr(input logic [7:0] v);
`ifdef TWELVE_HOUR_EN
    if (v == 8'h12) return 8'h01;
`else
    if (v == 8'h23) return 8'h00;
`endif
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [23:0]      count_q, count_d;
  logic [DIV_W-1:0] psc_q, psc_d;
  logic             tick_q, tick_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;
`ifdef TWELVE_HOUR_EN
  logic             pm_q, pm_d;
`endif

  logic       set_cyc, min_carry, hr_carry, hr_adv;
  logic [7:0] hr, mn, sc, hr_d, mn_d, sc_d;

  assign hr = count_q[23:16];
  assign mn = count_q[15:8];
  assign sc = count_q[7:0];

  always_comb begin
    set_cyc = clr_sec | inc_min | inc_hour;
    // A set cycle freezes the prescaler, so a tick due now simply fires on the next free cycle.
    tick_d  = run & ~set_cyc & (psc_q == PSC_LAST);
    psc_d   = psc_q;
    if (clr_sec)
      psc_d = '0;
    else if (run & ~set_cyc)
      psc_d = tick_d ? '0 : psc_q + DIV_W'(1);

    min_carry = tick_d & (sc == 8'h59);
    hr_carry  = min_carry & (mn == 8'h59);
    hr_adv    = inc_hour | hr_carry;

    sc_d = sc;
    mn_d = mn;
    hr_d = hr;
    if (clr_sec)
      sc_d = 8'h00;
    else if (tick_d)
      sc_d = inc_mod60(sc);
    if (inc_min | min_carry)
      mn_d = inc_mod60(mn);
    if (hr_adv)
      hr_d = inc_hr(hr);
    count_d    = {hr_d, mn_d, sc_d};
    sec_tick_d = tick_q;
`ifdef TWELVE_HOUR_EN
    pm_d       = pm_q ^ (hr_adv & (hr == 8'h11));
    day_wrap_d = hr_carry & (hr == 8'h11) & pm_q;
`else
    day_wrap_d = hr_carry & (hr == 8'h23);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= RST_COUNT;
      psc_q      <= '0;
      tick_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_q       <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      psc_q      <= psc_d;
      tick_q     <= tick_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
`ifdef TWELVE_HOUR_EN
      pm_q       <= pm_d;
`endif
    end
  end

  assign count    = count_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
`ifdef TWELVE_HOUR_EN
  assign pm       = pm_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Randomized bench for bcd_time_counter against a seconds-of-day reference model (TICK_DIV=4).
module tb_bcd_time_counter;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        inc_min = 1'b0;
  logic        inc_hour = 1'b0;
  logic        clr_sec = 1'b0;
  logic [23:0] count;
  logic        sec_tick, day_wrap;
`ifdef TWELVE_HOUR_EN
  logic        pm;
`endif

  bcd_time_counter #(.TICK_DIV(TD), .DIV_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .inc_min(inc_min), .inc_hour(inc_hour),
    .clr_sec(clr_sec), .count(count), .sec_tick(sec_tick), .day_wrap(day_wrap)
`ifdef TWELVE_HOUR_EN
    , .pm(pm)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int m_hr, m_mn, m_sc, m_psc;
  bit m_prev_tick, e_sec_tick, e_day_wrap;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_count();
    int hd;
    hd = m_hr;
`ifdef TWELVE_HOUR_EN
    hd = (m_hr % 12 == 0) ? 12 : m_hr % 12;
`endif
    return {4'(hd / 10), 4'(hd % 10), 4'(m_mn / 10), 4'(m_mn % 10), 4'(m_sc / 10), 4'(m_sc % 10)};
  endfunction

  task automatic model_reset();
    m_hr = 0; m_mn = 0; m_sc = 0; m_psc = 0;
    m_prev_tick = 0; e_sec_tick = 0; e_day_wrap = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_count"}, count, exp_count());
    check({pfx, "_sec_tick"}, 24'(sec_tick), 24'(e_sec_tick));
    check({pfx, "_day_wrap"}, 24'(day_wrap), 24'(e_day_wrap));
`ifdef TWELVE_HOUR_EN
    check({pfx, "_pm"}, 24'(pm), 24'(m_hr >= 12));
`endif
  endtask

  // One clock edge: drive inputs, advance the model by the same rules, compare #1 after the edge.
  task automatic step(input bit r, input bit ci, input bit cm, input bit ch);
    bit set, tick;
    int tod;
    run = r; clr_sec = ci; inc_min = cm; inc_hour = ch;
    @(posedge clk);
    set  = ci | cm | ch;
    tick = r && !set && (m_psc == TD - 1);
    e_sec_tick  = m_prev_tick;
    m_prev_tick = tick;
    e_day_wrap  = 0;
    if (set) begin
      if (ci) begin m_psc = 0; m_sc = 0; end
      if (cm) m_mn = (m_mn + 1) % 60;
      if (ch) m_hr = (m_hr + 1) % 24;
    end else if (r) begin
      m_psc = tick ? 0 : m_psc + 1;
    end
    if (tick) begin
      tod = m_hr * 3600 + m_mn * 60 + m_sc + 1;
      if (tod == 86400) begin tod = 0; e_day_wrap = 1; end
      m_hr = tod / 3600; m_mn = (tod / 60) % 60; m_sc = tod % 60;
    end
    #1;
    check_outputs("step");
    clr_sec = 0; inc_min = 0; inc_hour = 0;
  endtask

  task automatic goto_time(input int h, input int m);
    for (int i = 0; i < 30 && m_hr != h; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 70 && m_mn != m; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 300 && m_sc != 58; i++) step(1, 0, 0, 0);
    repeat (2 * TD + 2) step(1, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    run = 1'b1;
    #12;
    check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (13) step(1, 0, 0, 0);

    // Wrap checks on set pulses, then rollovers through noon and midnight.
    repeat (23) step(0, 0, 0, 1);
    repeat (60) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    goto_time(23, 59);
    goto_time(11, 59);
    goto_time(23, 59);

    // inc_min landing exactly on the final prescaler cycle.
    for (int i = 0; i < 8 && m_psc != TD - 1; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);

    // clr_sec mid-count, then a frozen stretch with run low.
    for (int i = 0; i < 400 && m_sc != 37; i++) step(1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (2 * TD + 1) step(1, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0);

    async_reset("midreset");
    repeat (10) step(1, 0, 0, 0);
    async_reset("midreset2");
    repeat (6) step(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
